// File: rtl/clk_div_sel_ctrl.sv
// Divided-clock generator and glitch-safe select sequencer for the clk_sel mux.
// The select line only moves while clk_div is low, GUARD cycles after its falling edge.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | select matches sel_req; busy=0
// WAIT_LOW | mismatch seen; waiting for the clk_div fall edge (or div_en=0)
// SETTLE   | guard interval running; select flips when gcnt reaches GUARD
module clk_div_sel_ctrl #(
    parameter int DIV_W = 4,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             sel_req,
    output logic             clk_div,
    output logic             select,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        SETTLE   = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_shadow;
    logic [3:0]       gcnt;
    logic             reload;
    logic             fall;

    // div_val is only sampled at a reload, so a half-period is never cut or stretched
    assign reload = div_en && (cnt == div_shadow);
    assign fall   = reload && clk_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div_shadow <= div_val;
            clk_div    <= 1'b0;
        end else if (!div_en) begin
            cnt        <= '0;
            div_shadow <= div_val;
            clk_div    <= 1'b0;
        end else if (reload) begin
            cnt        <= '0;
            div_shadow <= div_val;
            clk_div    <= ~clk_div;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gcnt   <= 4'd0;
            select <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_req != select) begin
                        state <= WAIT_LOW;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (sel_req == select) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!div_en || fall) begin
                        state <= SETTLE;
                        gcnt  <= 4'd1;
                    end
                end
                SETTLE: begin
                    // sel_req is deliberately ignored here; a new mismatch restarts from IDLE
                    if (gcnt == 4'(GUARD)) begin
                        select <= ~select;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sel_ctrl.sv
// Self-checking bench for clk_div_sel_ctrl: directed scenarios plus a randomized run,
// all compared against an event-time reference model.
module tb_clk_div_sel_ctrl;

    localparam int DIV_W = 4;
    localparam int GUARD = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             div_en = 1'b1;
    logic [DIV_W-1:0] div_val = 4'd5;
    logic             sel_req = 1'b0;
    logic             clk_div;
    logic             select;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    // reference model state: edge index, scheduled toggle/flip times
    int cyc = 0;
    int m_next_toggle = 0;
    int m_flip_at = -1;
    bit m_clk_div = 0, m_select = 0, m_busy = 0, m_done = 0, m_wait = 0;

    clk_div_sel_ctrl #(.DIV_W(DIV_W), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .div_en(div_en), .div_val(div_val), .sel_req(sel_req),
        .clk_div(clk_div), .select(select), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        bit fall;
        cyc++;
        fall = 0;
        if (rst || !div_en) begin
            m_clk_div = 0;
            m_next_toggle = cyc + int'(div_val) + 1;
        end else if (cyc == m_next_toggle) begin
            fall = m_clk_div;
            m_clk_div = !m_clk_div;
            m_next_toggle = cyc + int'(div_val) + 1;
        end
        if (rst) begin
            m_select = 0; m_busy = 0; m_done = 0; m_wait = 0; m_flip_at = -1;
        end else begin
            m_done = 0;
            if (m_flip_at >= 0) begin
                if (cyc == m_flip_at) begin
                    m_select = !m_select; m_done = 1; m_busy = 0; m_flip_at = -1;
                end
            end else if (m_wait) begin
                if (sel_req == m_select) begin
                    m_wait = 0; m_busy = 0;
                end else if (!div_en || fall) begin
                    m_wait = 0; m_flip_at = cyc + GUARD;
                end
            end else if (sel_req != m_select) begin
                m_wait = 1; m_busy = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int rise_at;
        rst = 1; div_en = 1; div_val = 4'd5; sel_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({clk_div, select, busy, done} !== 4'b0000 || dut.cnt !== 4'd0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got div/sel/busy/done=%b cnt=%0d, required 0000 cnt=0",
                         i, {clk_div, select, busy, done}, dut.cnt);
            end
        end
        rst = 0;
        rise_at = -1;
        for (int k = 1; k <= 20 && rise_at < 0; k++) begin
            tick();
            total++;
            if ({clk_div, select, busy, done} !== {m_clk_div, m_select, m_busy, m_done}) begin
                bad++;
                $display("FAIL reset_model@%0d: got %b, required %b", cyc,
                         {clk_div, select, busy, done}, {m_clk_div, m_select, m_busy, m_done});
            end
            if (clk_div === 1'b1) rise_at = k;
        end
        total++;
        if (rise_at != 6) begin
            bad++;
            $display("FAIL first_rise: got %0d cycles, required 6", rise_at);
        end
    endtask

    task automatic test_divider();
        int runs[$];
        int run;
        bit prev, seen;
        bit ok;
        div_en = 0; div_val = 4'd0;
        tick();
        div_en = 1;
        prev = clk_div; seen = 0; run = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 7) div_val = 4'd3;
            tick();
            total++;
            if ({clk_div, select, busy, done} !== {m_clk_div, m_select, m_busy, m_done}) begin
                bad++;
                $display("FAIL div_model@%0d: got %b, required %b", cyc,
                         {clk_div, select, busy, done}, {m_clk_div, m_select, m_busy, m_done});
            end
            if (clk_div != prev) begin
                if (seen) runs.push_back(run);
                seen = 1; run = 1;
            end else begin
                run++;
            end
            prev = clk_div;
        end
        ok = (runs.size() >= 6) && (runs[0] == 1) && (runs[runs.size()-1] == 4)
             && (runs[runs.size()-2] == 4);
        foreach (runs[i]) if (runs[i] != 1 && runs[i] != 4) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL half_periods: got %0d runs, first=%0d last=%0d, required runs of 1 then 4",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1,
                     (runs.size() > 0) ? runs[runs.size()-1] : -1);
        end
    endtask

    task automatic test_switch();
        bit prev;
        int fall_t, done_t, k;
        div_val = 4'd3; sel_req = 0;
        prev = clk_div;
        k = 0;
        do begin
            prev = clk_div; tick(); k++;
        end while (!(prev == 0 && clk_div == 1) && k < 30);
        sel_req = 1;
        tick();
        total++;
        if (busy !== 1'b1 || busy !== m_busy) begin
            bad++;
            $display("FAIL switch_busy: got %b, required 1", busy);
        end
        fall_t = -1; done_t = -1;
        for (int j = 0; j < 30 && done_t < 0; j++) begin
            prev = clk_div;
            tick();
            if (prev == 1 && clk_div == 0 && fall_t < 0) fall_t = cyc;
            if (done === 1'b1) begin
                done_t = cyc;
                total++;
                if (select !== 1'b1 || clk_div !== 1'b0) begin
                    bad++;
                    $display("FAIL switch_done_state: got select=%b clk_div=%b, required 1 0",
                             select, clk_div);
                end
            end
        end
        total++;
        if (fall_t < 0 || done_t - fall_t != GUARD) begin
            bad++;
            $display("FAIL switch_latency: got %0d edges after fall, required %0d",
                     done_t - fall_t, GUARD);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || select !== 1'b1) begin
            bad++;
            $display("FAIL switch_done_width: got done=%b busy=%b sel=%b, required 0 0 1",
                     done, busy, select);
        end
    endtask

    task automatic test_abort();
        bit prev;
        int k;
        int dones;
        k = 0;
        do begin
            prev = clk_div; tick(); k++;
        end while (!(prev == 0 && clk_div == 1) && k < 30);
        sel_req = 0;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_rise: got %b, required 1", busy);
        end
        sel_req = 1;
        tick();
        total++;
        if (busy !== 1'b0 || busy !== m_busy) begin
            bad++;
            $display("FAIL abort_busy_fall: got %b, required 0", busy);
        end
        dones = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || select !== 1'b1) begin
            bad++;
            $display("FAIL abort_no_switch: got dones=%0d select=%b, required 0 1", dones, select);
        end
    endtask

    task automatic test_disabled();
        int busy_t, done_t;
        bit div_hi;
        div_en = 0; sel_req = 0;
        busy_t = -1; done_t = -1; div_hi = 0;
        for (int j = 0; j < 20 && done_t < 0; j++) begin
            tick();
            if (clk_div !== 1'b0) div_hi = 1;
            if (busy === 1'b1 && busy_t < 0) busy_t = cyc;
            if (done === 1'b1) done_t = cyc;
            total++;
            if ({clk_div, select, busy, done} !== {m_clk_div, m_select, m_busy, m_done}) begin
                bad++;
                $display("FAIL dis_model@%0d: got %b, required %b", cyc,
                         {clk_div, select, busy, done}, {m_clk_div, m_select, m_busy, m_done});
            end
        end
        total++;
        if (busy_t < 0 || done_t - busy_t != GUARD + 1 || select !== 1'b0 || div_hi) begin
            bad++;
            $display("FAIL dis_latency: got %0d edges sel=%b div_hi=%b, required %0d 0 0",
                     done_t - busy_t, select, div_hi, GUARD + 1);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int dones;
        div_en = 1; div_val = 4'd3; sel_req = 1;
        k = 0;
        do begin tick(); k++; end while (m_flip_at < 0 && k < 30);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL rmid_settle: got busy=%b done=%b, required 1 0", busy, done);
        end
        rst = 1;
        tick();
        total++;
        if ({select, busy, done, clk_div} !== 4'b0000) begin
            bad++;
            $display("FAIL rmid_reset: got sel/busy/done/div=%b, required 0000",
                     {select, busy, done, clk_div});
        end
        rst = 0;
        tick();
        total++;
        if (busy !== 1'b1 || select !== 1'b0) begin
            bad++;
            $display("FAIL rmid_restart: got busy=%b sel=%b, required 1 0", busy, select);
        end
        dones = 0;
        for (int j = 0; j < 30; j++) begin
            tick();
            if (done === 1'b1) dones++;
            total++;
            if ({clk_div, select, busy, done} !== {m_clk_div, m_select, m_busy, m_done}) begin
                bad++;
                $display("FAIL rmid_model@%0d: got %b, required %b", cyc,
                         {clk_div, select, busy, done}, {m_clk_div, m_select, m_busy, m_done});
            end
        end
        total++;
        if (dones != 1 || select !== 1'b1) begin
            bad++;
            $display("FAIL rmid_complete: got dones=%0d sel=%b, required 1 1", dones, select);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 2000; j++) begin
            rst = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 8) div_en = ~div_en;
            if (!div_en && $urandom_range(99) < 30) div_en = 1;
            if ($urandom_range(99) < 5) div_val = 4'($urandom_range(6, GUARD));
            if ($urandom_range(99) < 7) sel_req = ~sel_req;
            tick();
            total++;
            if ({clk_div, select, busy, done} !== {m_clk_div, m_select, m_busy, m_done}) begin
                bad++;
                $display("FAIL rand_model@%0d: got %b, required %b", cyc,
                         {clk_div, select, busy, done}, {m_clk_div, m_select, m_busy, m_done});
            end
            if (done === 1'b1) begin
                total++;
                if (clk_div !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_sel_while_low@%0d: got clk_div=%b, required 0", cyc, clk_div);
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_switch();
        test_abort();
        test_disabled();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_sel_ctrl.md
Name: clk_div_sel_ctrl

Overview:
Upstream companion to the two-input clock mux (clk_sel). It generates the divided clock that drives the mux's clk2 input. It also generates the mux's select line.
- select changes only while the divided clock is low, after a programmable guard interval, so the mux never switches mid-pulse.
- A level request / done-pulse interface lets the rest of the design ask for a clock change and learn when it has taken effect.

Parameters:
DIV_W, 4, width of divide-value input and half-period counter
GUARD, 2, clk cycles between divided-clock falling edge and select update (1..15)

Ports:
clk  input  1  system clock; also drives mux clk1
rst  input  1  synchronous active-high reset
div_en  input  1  1 = divider runs; 0 = clk_div held low
div_val  input  DIV_W  half-period minus one, in clk cycles
sel_req  input  1  requested select level (0 = clk1, 1 = clk2)
clk_div  output  1  registered divided clock, to mux clk2
select  output  1  registered select, to mux select
busy  output  1  switch sequence in progress
done  output  1  one-cycle pulse on the edge where select changes

Behaviour:
- Reset (rst=1 at a clock edge): on that edge cnt=0, div_shadow=div_val, clk_div=0, select=0, busy=0, done=0, state=IDLE. Reset applies mid-sequence too; no partial switch completes.
- Divider, div_en=1:
  - cnt increments each cycle.
  - When cnt==div_shadow: cnt<=0, clk_div toggles, div_shadow<=div_val.
  - Half-period is div_shadow+1 cycles; period is 2*(div_val+1). div_val=0 gives clk/2.
- Divider, div_en=0: cnt<=0, clk_div<=0, div_shadow<=div_val every cycle. Re-enable starts with clk_div low for div_shadow+1 cycles, then rises.
- div_val changes mid-period take effect only at the next reload. No truncated or stretched current half-period.
- Fall edge: the clock edge at which clk_div goes 1->0 (cnt==div_shadow and clk_div==1 in the preceding cycle).
- FSM states:
  - IDLE: busy=0. If sel_req!=select -> WAIT_LOW, busy=1 on the same edge.
  - WAIT_LOW:
    - If sel_req==select again -> IDLE, busy=0, no done.
    - Else if div_en=0 -> SETTLE on the next edge.
    - Else -> SETTLE on the fall edge. gcnt<=1 on entry.
  - SETTLE:
    - gcnt increments each edge. sel_req changes are ignored.
    - On the edge where gcnt==GUARD: select<=~select, done<=1, busy<=0, state<=IDLE.
    - Net effect: select updates exactly GUARD edges after the fall edge.
  - done is high for exactly one cycle, otherwise 0.
- A pending mismatch (sel_req toggled during SETTLE) starts a new sequence from IDLE on the following edge.
- GUARD must be <= div_val, so select changes while clk_div is still low. This is an integration requirement; the block does not check it.
- If clk_div rises before the switch (GUARD > div_val), the switch still completes; the bench flags it as a configuration error only.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. rst=1 for 3 cycles with div_en=1, div_val=5 -> clk_div=0, select=0, busy=0, done=0, cnt=0 throughout; first clk_div rise 6 cycles after rst drops.
2. div_en=1, div_val=0 then div_val=3 -> clk_div period 2 cycles; after the change, next full half-period 4 cycles high / 4 low. No half-period shorter than the old or longer than the new value.
3. div_val=3, GUARD=2, sel_req 0->1 while clk_div high -> busy rises next edge; select=1 and done=1 exactly 2 edges after the fall edge; clk_div still low; done is one cycle wide.
4. sel_req 0->1 then back to 0 before the fall edge -> busy returns to 0, select stays 0, no done pulse.
5. div_en=0, sel_req 1->0 -> select=0 and done pulse GUARD+1 edges after busy rises; clk_div stays 0.
6. rst asserted while in SETTLE -> select stays at its pre-sequence value (reset value 0), busy=0, no done; sequence restarts after reset if sel_req still differs.
